lh_sweep_timestamper: RTL and testbench

Parametrised multi-sensor Lighthouse front end that replaces the fixed per-sensor pulse capture. It measures every active-low envelope pulse on NUM_SENSORS photodiode inputs, classifies each pulse as sync or sweep hit, and decodes the sync width into skip/data/axis bits. It timestamps hit centres against the last non-skip sync and queues 32-bit hit records in a FIFO for the SPI packer.

---
 rtl/lh_sweep_timestamper_if.sv | 10 +
 rtl/lh_sweep_timestamper.sv | 244 ++++++++++++++++++++++++
 tb/tb_lh_sweep_timestamper.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lh_sweep_timestamper_if.sv
// Hit-record stream between the sweep timestamper and the SPI packer.
// First-word-fall-through: data is valid whenever valid is high; a word pops on valid && ready.
interface lh_sweep_timestamper_if;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lh_sweep_timestamper.sv
// Multi-sensor Lighthouse front end: measures envelope pulses, decodes syncs and queues
// 32-bit sweep-hit records timestamped against the last non-skip sync.
module lh_sweep_timestamper #(
  parameter int unsigned NUM_SENSORS    = 5,
  parameter int unsigned SYNC_BASE      = 3000,
  parameter int unsigned SYNC_STEP      = 500,
  parameter int unsigned WIDTH_SHIFT    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 480000,
  parameter int unsigned DEPTH          = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_SENSORS-1:0] i_lh_sensor,
  lh_sweep_timestamper_if.master o_rec,
  output logic [3:0]             o_last_sync,
  output logic                   o_synced,
  output logic                   o_overflow,
  input  logic                   i_clear_overflow
);

  localparam int unsigned SyncMin     = SYNC_BASE - SYNC_STEP;
  localparam int unsigned SyncLim2    = 2 * SYNC_BASE + 15 * SYNC_STEP;
  localparam int unsigned MergeCycles = 2 * SYNC_BASE;
  localparam int unsigned MergeW      = $clog2(MergeCycles + 1);
  localparam int unsigned TimeoutW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StationWin  = 24000;
  localparam int unsigned AddrW       = $clog2(DEPTH);
  localparam logic [13:0] WidthMax    = 14'h3FFF;

  typedef enum logic [1:0] {StWaitHigh, StHigh, StLow} sens_st_e;

  logic [NUM_SENSORS-1:0] r_meta, r_sync;
  sens_st_e               r_st        [NUM_SENSORS];
  logic [18:0]            r_start     [NUM_SENSORS];
  logic [13:0]            r_width     [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_evt_v;
  logic [18:0]            r_evt_start [NUM_SENSORS];
  logic [13:0]            r_evt_width [NUM_SENSORS];
  logic [18:0]            r_timer;

  logic [MergeW-1:0]      r_merge_cnt;
  logic [18:0]            r_prev_start;
  logic                   r_have_prev;
  logic [3:0]             r_last_sync;
  logic [18:0]            r_ref_start;
  logic                   r_ref_axis, r_ref_station;
  logic                   r_synced;
  logic [TimeoutW-1:0]    r_to_cnt;

  logic [NUM_SENSORS-1:0] r_slot_v;
  logic [31:0]            r_slot [NUM_SENSORS];
  logic                   r_overflow;

  logic [31:0]            r_mem [DEPTH];
  logic [AddrW:0]         r_wr_ptr, r_rd_ptr;

  logic [NUM_SENSORS-1:0] w_is_hit, w_is_sync, w_new, w_collide, w_gnt;
  logic [31:0]            w_rec [NUM_SENSORS];
  logic                   w_sync_hit, w_accept, w_station;
  logic [18:0]            w_sync_start;
  logic [13:0]            w_sync_w;
  logic [2:0]             w_code;
  logic [31:0]            w_grant_data;
  logic                   w_grant_v, w_empty, w_full, w_pop, w_push, w_drop_full;

  // Sync code n: largest k with 2w >= 2*BASE + (2k-1)*STEP, i.e. half-step thresholds.
  function automatic logic [2:0] sync_code(input logic [13:0] w);
    logic [2:0] n;
    n = '0;
    for (int k = 1; k < 8; k++) begin
      if (2 * int'(w) >= 2 * int'(SYNC_BASE) + (2 * k - 1) * int'(SYNC_STEP)) n = 3'(k);
    end
    return n;
  endfunction

  // Synchronisers, per-sensor pulse FSMs and the free-running timer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_evt_v <= '0;
      r_timer <= '0;
      for (int i = 0; i < int'(NUM_SENSORS); i++) begin
        r_st[i]        <= StWaitHigh;
        r_start[i]     <= '0;
        r_width[i]     <= '0;
        r_evt_start[i] <= '0;
        r_evt_width[i] <= '0;
      end
    end else begin
      r_meta  <= i_lh_sensor;
      r_sync  <= r_meta;
      r_evt_v <= '0;
      r_timer <= r_timer + 19'd1;
      for (int i = 0; i < int'(NUM_SENSORS); i++) begin
        case (r_st[i])
          StWaitHigh: if (r_sync[i]) r_st[i] <= StHigh;
          StHigh: begin
            if (!r_sync[i]) begin
              r_st[i]    <= StLow;
              r_start[i] <= r_timer;
              r_width[i] <= 14'd1;
            end
          end
          StLow: begin
            if (r_sync[i]) begin
              r_st[i]        <= StHigh;
              r_evt_v[i]     <= 1'b1;
              r_evt_start[i] <= r_start[i];
              r_evt_width[i] <= r_width[i];
            end else if (r_width[i] != WidthMax) begin
              r_width[i] <= r_width[i] + 14'd1;
            end
          end
          default: r_st[i] <= StWaitHigh;
        endcase
      end
    end
  end

  // Classification, record formatting and lowest-index selection.
  always_comb begin
    w_is_hit     = '0;
    w_is_sync    = '0;
    w_new        = '0;
    w_collide    = '0;
    w_gnt        = '0;
    w_sync_hit   = 1'b0;
    w_sync_start = '0;
    w_sync_w     = '0;
    w_grant_data = '0;
    for (int i = 0; i < int'(NUM_SENSORS); i++) begin
      logic [18:0]    ts;
      logic [13:0]    sh;
      logic [7:0]     wf;
      int unsigned    w;
      w            = 32'(r_evt_width[i]);
      w_is_hit[i]  = r_evt_v[i] && (w < SyncMin);
      w_is_sync[i] = r_evt_v[i] && (w >= SyncMin) && (2 * w < SyncLim2);
      ts           = r_evt_start[i] - r_ref_start + 19'(r_evt_width[i] >> 1);
      sh           = r_evt_width[i] >> WIDTH_SHIFT;
      wf           = (sh > 14'd255) ? 8'hFF : sh[7:0];
      w_rec[i]     = {3'(i), r_ref_station, r_ref_axis, ts, wf};
      w_new[i]     = w_is_hit[i] && r_synced;
      w_collide[i] = w_new[i] && r_slot_v[i];
    end
    for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
      if (w_is_sync[i]) begin
        w_sync_hit   = 1'b1;
        w_sync_start = r_evt_start[i];
        w_sync_w     = r_evt_width[i];
      end
    end
    for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
      if (r_slot_v[i] || w_new[i]) begin
        w_gnt        = '0;
        w_gnt[i]     = 1'b1;
        w_grant_data = r_slot_v[i] ? r_slot[i] : w_rec[i];
      end
    end
  end

  assign w_accept    = w_sync_hit && (r_merge_cnt == '0);
  assign w_code      = sync_code(w_sync_w);
  assign w_station   = r_have_prev && ((w_sync_start - r_prev_start) < 19'(StationWin));
  assign w_grant_v   = |w_gnt;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                       (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
  assign w_pop       = !w_empty && o_rec.ready;
  // A full FIFO still accepts a write when the same cycle pops.
  assign w_push      = w_grant_v && (!w_full || w_pop);
  assign w_drop_full = w_grant_v && !w_push;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_merge_cnt   <= '0;
      r_prev_start  <= '0;
      r_have_prev   <= 1'b0;
      r_last_sync   <= '0;
      r_ref_start   <= '0;
      r_ref_axis    <= 1'b0;
      r_ref_station <= 1'b0;
      r_synced      <= 1'b0;
      r_to_cnt      <= '0;
      r_slot_v      <= '0;
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      for (int i = 0; i < int'(NUM_SENSORS); i++) r_slot[i] <= '0;
    end else begin
      if (w_accept) begin
        r_merge_cnt  <= MergeW'(MergeCycles);
        r_prev_start <= w_sync_start;
        r_have_prev  <= 1'b1;
        r_last_sync  <= {w_station, w_code};
      end else if (r_merge_cnt != '0) begin
        r_merge_cnt <= r_merge_cnt - MergeW'(1);
      end

      if (w_accept && !w_code[2]) begin
        r_ref_start   <= w_sync_start;
        r_ref_axis    <= w_code[0];
        r_ref_station <= w_station;
        r_synced      <= 1'b1;
        r_to_cnt      <= '0;
      end else if (r_synced) begin
        if (r_to_cnt == TimeoutW'(TIMEOUT_CYCLES - 1)) begin
          r_synced <= 1'b0;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TimeoutW'(1);
        end
      end

      // A new hit only parks in its slot when it was not written straight through.
      for (int i = 0; i < int'(NUM_SENSORS); i++) begin
        if (w_gnt[i]) begin
          r_slot_v[i] <= 1'b0;
        end else if (!r_slot_v[i] && w_new[i]) begin
          r_slot_v[i] <= 1'b1;
          r_slot[i]   <= w_rec[i];
        end
      end

      if ((|w_collide) || w_drop_full) r_overflow <= 1'b1;
      else if (i_clear_overflow)       r_overflow <= 1'b0;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AddrW-1:0]] <= w_grant_data;
  end

  assign o_rec.valid = !w_empty;
  assign o_rec.data  = w_empty ? 32'd0 : r_mem[r_rd_ptr[AddrW-1:0]];
  assign o_last_sync = r_last_sync;
  assign o_synced    = r_synced;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_lh_sweep_timestamper.sv
// Directed bench for lh_sweep_timestamper with a shortened sync timeout so the run stays short.
// All stimulus is driven and all outputs are sampled on the falling clock edge.
module tb_lh_sweep_timestamper;
  localparam int unsigned NS = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] sens = '1;
  logic          clr = 1'b0;
  logic [3:0]    last_sync;
  logic          synced, ovf;
  int            total = 0;
  int            bad   = 0;

  lh_sweep_timestamper_if rec_if ();

  always #5 clk = ~clk;

  lh_sweep_timestamper #(
    .NUM_SENSORS    (NS),
    .SYNC_BASE      (3000),
    .SYNC_STEP      (500),
    .WIDTH_SHIFT    (2),
    .TIMEOUT_CYCLES (20000),
    .DEPTH          (16)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_lh_sensor      (sens),
    .o_rec            (rec_if),
    .o_last_sync      (last_sync),
    .o_synced         (synced),
    .o_overflow       (ovf),
    .i_clear_overflow (clr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sens         = '1;
    rec_if.ready = 1'b0;
    clr          = 1'b0;
    rst          = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic low_pulse(input logic [NS-1:0] m, input int n);
    sens = sens & ~m;
    cyc(n);
    sens = sens | m;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    int k;
    k = 0;
    while (!rec_if.valid && k < 50) begin
      cyc(1);
      k++;
    end
    check_val({tag, "_valid"}, 32'(rec_if.valid), 32'd1);
    check_val(tag, rec_if.data, exp);
    rec_if.ready = 1'b1;
    cyc(1);
    rec_if.ready = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_if.ready = 1'b0;
    // Reset state after a long idle with all inputs high
    cyc(5);
    rst = 1'b0;
    cyc(1000);
    check_val("rst_valid", 32'(rec_if.valid), 32'd0);
    check_val("rst_data", rec_if.data, 32'd0);
    check_val("rst_synced", 32'(synced), 32'd0);
    check_val("rst_last", 32'(last_sync), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);

    // 4080-cycle sync on every sensor: code 2, then a hit 10000 cycles after sync start
    low_pulse(5'h1F, 4080);
    cyc(10);
    check_val("t2_last", 32'(last_sync), 32'h2);
    check_val("t2_synced", 32'(synced), 32'd1);
    cyc(5910);
    low_pulse(5'h04, 480);
    pop_check("t2_rec", 32'h40280078);
    cyc(5);
    check_val("t2_empty", 32'(rec_if.valid), 32'd0);

    // Skip sync with no reference: hits are dropped silently
    do_reset();
    low_pulse(5'h01, 5080);
    cyc(10);
    check_val("t3_last", 32'(last_sync), 32'h4);
    check_val("t3_synced", 32'(synced), 32'd0);
    low_pulse(5'h02, 480);
    cyc(20);
    check_val("t3_norec", 32'(rec_if.valid), 32'd0);
    check_val("t3_ovf", 32'(ovf), 32'd0);

    // Axis-1 sync, then all five sensors hit together: records drain in index order
    do_reset();
    low_pulse(5'h01, 3500);
    cyc(10);
    check_val("t4_last", 32'(last_sync), 32'h1);
    cyc(4490);
    low_pulse(5'h1F, 480);
    for (int s = 0; s < 5; s++) pop_check("t4_rec", (32'(s) << 29) | 32'h08203078);
    cyc(5);
    check_val("t4_empty", 32'(rec_if.valid), 32'd0);

    // FIFO fill with ready low: 16 fit, the 17th overflows
    do_reset();
    low_pulse(5'h01, 4080);
    cyc(1920);
    for (int j = 0; j < 16; j++) begin
      low_pulse(5'h01, 100);
      cyc(100);
    end
    check_val("t5_ovf16", 32'(ovf), 32'd0);
    check_val("t5_valid16", 32'(rec_if.valid), 32'd1);
    low_pulse(5'h01, 100);
    cyc(100);
    check_val("t5_ovf17", 32'(ovf), 32'd1);
    check_val("t5_hold", rec_if.data, 32'h0017A219);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check_val("t5_clr", 32'(ovf), 32'd0);
    for (int j = 0; j < 16; j++) pop_check("t5_rec", 32'h0017A219 + (32'(j * 200) << 8));
    cyc(5);
    check_val("t5_empty", 32'(rec_if.valid), 32'd0);

    // Sync timeout, then reset in the middle of a sensor-1 pulse
    do_reset();
    low_pulse(5'h01, 4080);
    cyc(10);
    check_val("t6_synced", 32'(synced), 32'd1);
    cyc(18000);
    check_val("t6_before_to", 32'(synced), 32'd1);
    cyc(3000);
    check_val("t6_after_to", 32'(synced), 32'd0);
    low_pulse(5'h04, 480);
    cyc(30);
    check_val("t6_norec", 32'(rec_if.valid), 32'd0);
    check_val("t6_ovf", 32'(ovf), 32'd0);
    sens[1] = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(5);
    low_pulse(5'h01, 4080);
    cyc(10);
    check_val("t6_resync", 32'(synced), 32'd1);
    check_val("t6_last", 32'(last_sync), 32'h2);
    cyc(910);
    sens[1] = 1'b1;
    cyc(50);
    check_val("t6_rise_norec", 32'(rec_if.valid), 32'd0);
    cyc(950);
    low_pulse(5'h02, 480);
    pop_check("t6_rec", 32'h20186078);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
